// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and helpers for the sp_ram_ctrl front-end controller.
package sp_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sp_ram_ctrl_fifo.sv
// Synchronous fall-through FIFO for read responses; exposes its occupancy.
module sp_ram_ctrl_fifo
  import sp_ram_ctrl_pkg::*;
#(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          head_valid,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Upstream credit accounting must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst && push && !do_pop) begin
      assert (count_q < CW'(DEPTH));
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM front-end: arbitrates write/read streams, tracks read latency,
// returns ordered read data. Define SP_RAM_CTRL_RR_ARB_EN for round-robin arbitration.
module sp_ram_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int unsigned AW             = 3,
  parameter int unsigned DW             = 4,
  parameter int unsigned READ_LATENCY_A = 3,
  parameter int unsigned FIFO_DEPTH     = READ_LATENCY_A + 2
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [DW-1:0] rdata,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic          ram_regcea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  input  logic [DW-1:0] ram_douta
);

  localparam int unsigned CW  = cnt_width(FIFO_DEPTH);
  localparam int unsigned SRW = READ_LATENCY_A + 1;

  grant_e        grant;
  logic          rd_ok;
  logic [31:0]   outstanding;
  logic [CW-1:0] fifo_count;

  logic          ram_ena_q, ram_ena_d;
  logic          ram_wea_q, ram_wea_d;
  logic [AW-1:0] ram_addra_q, ram_addra_d;
  logic [DW-1:0] ram_dina_q, ram_dina_d;
  logic [SRW-1:0] sr_q, sr_d;

`ifdef SP_RAM_CTRL_RR_ARB_EN
  logic last_wr_q, last_wr_d;
`endif

  // Reads in the RAM pipeline plus reads parked in the FIFO must fit the FIFO.
  always_comb begin
    outstanding = 32'($countones(sr_q)) + 32'(fifo_count);
    rd_ok       = rd_valid && (outstanding < FIFO_DEPTH);
    grant       = GNT_NONE;
    if (!rsta) begin
`ifdef SP_RAM_CTRL_RR_ARB_EN
      if (wr_valid && rd_ok) begin
        grant = last_wr_q ? GNT_RD : GNT_WR;
      end else if (wr_valid) begin
        grant = GNT_WR;
      end else if (rd_ok) begin
        grant = GNT_RD;
      end
`else
      if (wr_valid) begin
        grant = GNT_WR;
      end else if (rd_ok) begin
        grant = GNT_RD;
      end
`endif
    end
  end

  assign wr_ready = (grant == GNT_WR);
  assign rd_ready = (grant == GNT_RD);

  always_comb begin
    ram_ena_d   = 1'b1;
    ram_wea_d   = (grant == GNT_WR);
    ram_addra_d = ram_addra_q;
    ram_dina_d  = ram_dina_q;
    if (grant == GNT_WR) begin
      ram_addra_d = wr_addr;
      ram_dina_d  = wr_data;
    end else if (grant == GNT_RD) begin
      ram_addra_d = rd_addr;
    end
    // Bit k set means a read issued k+1 edges ago; the top bit lines up with valid douta.
    sr_d = {sr_q[SRW-2:0], (grant == GNT_RD)};
`ifdef SP_RAM_CTRL_RR_ARB_EN
    last_wr_d = last_wr_q;
    if (grant == GNT_WR) begin
      last_wr_d = 1'b1;
    end else if (grant == GNT_RD) begin
      last_wr_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      ram_ena_q   <= 1'b0;
      ram_wea_q   <= 1'b0;
      ram_addra_q <= '0;
      ram_dina_q  <= '0;
      sr_q        <= '0;
`ifdef SP_RAM_CTRL_RR_ARB_EN
      last_wr_q   <= 1'b0;
`endif
    end else begin
      ram_ena_q   <= ram_ena_d;
      ram_wea_q   <= ram_wea_d;
      ram_addra_q <= ram_addra_d;
      ram_dina_q  <= ram_dina_d;
      sr_q        <= sr_d;
`ifdef SP_RAM_CTRL_RR_ARB_EN
      last_wr_q   <= last_wr_d;
`endif
    end
  end

  sp_ram_ctrl_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clka),
    .rst        (rsta),
    .push       (sr_q[SRW-1]),
    .push_data  (ram_douta),
    .pop        (rdata_ready),
    .head_valid (rdata_valid),
    .head_data  (rdata),
    .count      (fifo_count)
  );

  assign ram_ena    = ram_ena_q;
  assign ram_regcea = ram_ena_q;
  assign ram_wea    = ram_wea_q;
  assign ram_addra  = ram_addra_q;
  assign ram_dina   = ram_dina_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Self-checking bench for sp_ram_ctrl with a behavioural RAM and reference model.
module tb_sp_ram_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 4;
  localparam int unsigned L  = 3;
  localparam int unsigned FD = L + 2;

  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          wr_valid = 1'b0, rd_valid = 1'b0, rdata_ready = 1'b1;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_ready, rdata_valid;
  logic [DW-1:0] rdata;
  logic          ram_ena, ram_wea, ram_regcea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina, ram_douta;

  always #5 clka = ~clka;

  sp_ram_ctrl #(
    .AW             (AW),
    .DW             (DW),
    .READ_LATENCY_A (L),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clka        (clka),
    .rsta        (rsta),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .ram_ena     (ram_ena),
    .ram_wea     (ram_wea),
    .ram_regcea  (ram_regcea),
    .ram_addra   (ram_addra),
    .ram_dina    (ram_dina),
    .ram_douta   (ram_douta)
  );

  // Behavioural read-first single-port RAM with L-cycle read latency.
  logic [DW-1:0] ram_mem  [2**AW];
  logic [DW-1:0] ram_pipe [L];
  always @(posedge clka) begin
    if (ram_ena) begin
      ram_pipe[0] <= ram_mem[ram_addra];
      for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
      if (ram_wea) ram_mem[ram_addra] <= ram_dina;
    end
  end
  assign ram_douta = ram_pipe[L-1];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: memory contents, expected responses with due cycle.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  logic [DW-1:0] model_mem [2**AW];
  resp_t         rq[$];
  bit            grant_log[$];
  int            cyc = 0;
  int            outstanding = 0;
  int            rd_acc_cnt = 0;
  bit            last_wr = 1'b0;
  bit            rst_seen = 1'b0;
  bit            pend_valid = 1'b0, pend_we = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;
  bit            exp_wr, exp_rd, exp_valid, rd_ok;

  always @(negedge clka) begin
    cyc++;
    if (rsta) begin
      check("wr_ready_rst", 32'(wr_ready), 32'(0));
      check("rd_ready_rst", 32'(rd_ready), 32'(0));
      rq.delete();
      outstanding = 0;
      pend_valid  = 1'b0;
      last_wr     = 1'b0;
      rst_seen    = 1'b1;
    end else begin
      if (rst_seen) begin
        check("ena_rst", 32'(ram_ena), 32'(0));
        check("regcea_rst", 32'(ram_regcea), 32'(0));
        check("addra_rst", 32'(ram_addra), 32'(0));
        check("dina_rst", 32'(ram_dina), 32'(0));
        check("rdata_rst", 32'(rdata), 32'(0));
        rst_seen = 1'b0;
      end else begin
        check("ena", 32'(ram_ena), 32'(1));
        check("regcea", 32'(ram_regcea), 32'(1));
      end
      if (pend_valid) begin
        check("issue_wea", 32'(ram_wea), 32'(pend_we));
        check("issue_addr", 32'(ram_addra), 32'(pend_addr));
        if (pend_we) check("issue_din", 32'(ram_dina), 32'(pend_data));
      end else begin
        check("idle_wea", 32'(ram_wea), 32'(0));
      end
      rd_ok = rd_valid && (outstanding < FD);
`ifdef SP_RAM_CTRL_RR_ARB_EN
      if (wr_valid && rd_ok) begin
        exp_wr = !last_wr;
        exp_rd = last_wr;
      end else begin
        exp_wr = wr_valid;
        exp_rd = rd_ok && !wr_valid;
      end
`else
      exp_wr = wr_valid;
      exp_rd = rd_ok && !wr_valid;
`endif
      check("wr_ready", 32'(wr_ready), 32'(exp_wr));
      check("rd_ready", 32'(rd_ready), 32'(exp_rd));
      exp_valid = (rq.size() > 0) && (rq[0].due <= cyc);
      check("rdata_valid", 32'(rdata_valid), 32'(exp_valid));
      if (rdata_valid && exp_valid) check("rdata", 32'(rdata), 32'(rq[0].data));
      if (rdata_valid && rdata_ready && rq.size() > 0) begin
        void'(rq.pop_front());
        outstanding--;
      end
      pend_valid = 1'b0;
      if (wr_valid && wr_ready) begin
        model_mem[wr_addr] = wr_data;
        pend_valid = 1'b1; pend_we = 1'b1; pend_addr = wr_addr; pend_data = wr_data;
        last_wr = 1'b1;
        grant_log.push_back(1'b1);
      end
      if (rd_valid && rd_ready) begin
        // Accepted before edge E0; valid visible L+2 negedges later (after E_(L+1)).
        rq.push_back('{data: model_mem[rd_addr], due: cyc + L + 2});
        outstanding++;
        rd_acc_cnt++;
        pend_valid = 1'b1; pend_we = 1'b0; pend_addr = rd_addr;
        last_wr = 1'b0;
        grant_log.push_back(1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      #1;
      acc = wr_ready;
      step();
    end
    wr_valid = 1'b0;
    if (!acc) check("wr_timeout", 32'(acc), 32'(1));
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    bit acc = 1'b0;
    rd_valid = 1'b1; rd_addr = a;
    for (int t = 0; t < 200 && !acc; t++) begin
      #1;
      acc = rd_ready;
      step();
    end
    rd_valid = 1'b0;
    if (!acc) check("rd_timeout", 32'(acc), 32'(1));
  endtask

  bit         wr_done, rd_done;
  logic [5:0] seq, exp_seq;

  initial begin
    repeat (3) step();
    rsta = 1'b0;
    step();

    for (int i = 0; i < 8; i++) do_wr(AW'(i), DW'(i));
    for (int i = 0; i < 8; i++) do_rd(AW'(i));
    repeat (10) step();

    // Back-pressure: only FIFO_DEPTH reads may be outstanding.
    rdata_ready = 1'b0;
    rd_acc_cnt  = 0;
    fork
      for (int k = 0; k < 10; k++) do_rd(AW'(k % 8));
      begin
        repeat (15) step();
        check("bp_accepts", 32'(rd_acc_cnt), 32'(FD));
        rdata_ready = 1'b1;
      end
    join
    repeat (10) step();
    check("bp_total", 32'(rd_acc_cnt), 32'(10));

    // Contention: 4 writes and 2 reads presented together.
    grant_log.delete();
    fork
      for (int k = 0; k < 4; k++) do_wr(AW'(k + 2), DW'($urandom));
      for (int k = 0; k < 2; k++) do_rd(AW'(k));
    join
    seq = '0;
    for (int i = 0; i < 6; i++) seq = {seq[4:0], (grant_log.size() > i) ? grant_log[i] : 1'b0};
`ifdef SP_RAM_CTRL_RR_ARB_EN
    exp_seq = 6'b101011;
`else
    exp_seq = 6'b111100;
`endif
    check("arb_seq", 32'(seq), 32'(exp_seq));
    repeat (8) step();

    do_wr(AW'(5), DW'(4'hA));
    do_rd(AW'(5));
    repeat (8) step();

    // Reset with three reads in flight.
    do_rd(AW'(1));
    do_rd(AW'(2));
    do_rd(AW'(3));
    rsta = 1'b1;
    step();
    rsta = 1'b0;
    repeat (10) step();

    // Random traffic with random consumer back-pressure.
    wr_done = 1'b0;
    rd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 2)) step();
          do_wr(AW'($urandom), DW'($urandom));
        end
        wr_done = 1'b1;
      end
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 2)) step();
          do_rd(AW'($urandom));
        end
        rd_done = 1'b1;
      end
      begin
        for (int t = 0; t < 5000 && !(wr_done && rd_done); t++) begin
          rdata_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    rdata_ready = 1'b1;
    repeat (20) step();
    check("drain", 32'(rq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
